// File: rtl/adc_control_nonbinary_pkg.sv
// Shared constants, types and helpers for the non-binary SAR controller.
// W[i] is the DAC weight of capacitor i (index 0 = smallest).
package adc_control_nonbinary_pkg;

  localparam int N_WEIGHTS   = 10;
  localparam int N_AVG_STEPS = 4;
  localparam int REP_W       = 6;

  // Redundant weights: each W[i] <= 1 + sum of lower weights, total 1023.
  localparam int unsigned W [N_WEIGHTS] = '{5, 6, 10, 18, 40, 64, 96, 144, 240, 400};

  typedef enum logic [1:0] {
    ST_SAMPLE,
    ST_STEP,
    ST_DONE
  } state_t;

  function automatic int unsigned weight(input int i);
    if (i < 0 || i >= N_WEIGHTS) return 0;
    return W[i[3:0]];
  endfunction

  function automatic logic [REP_W-1:0] avg_to_rep(input logic [2:0] avg);
    logic [REP_W-1:0] r;
    case (avg)
      3'd0:    r = REP_W'(1);
      3'd1:    r = REP_W'(4);
      3'd2:    r = REP_W'(8);
      3'd3:    r = REP_W'(16);
      default: r = REP_W'(32);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/adc_avg_vote.sv
// Repeat/ones counter for one averaged SAR step; vote is the majority
// including the current comparator sample, valid on the last repeat.
module adc_avg_vote
  import adc_control_nonbinary_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             comparator_in,
  input  logic [REP_W-1:0] rep,
  output logic             last,
  output logic             vote
);

  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] ones;
  logic [REP_W-1:0] ones_nxt;

  assign ones_nxt = ones + {{(REP_W-1){1'b0}}, comparator_in};
  assign last     = (rep_cnt == rep - REP_W'(1));
  // Tie (2*ones == R) resolves to 1.
  assign vote     = ({ones_nxt, 1'b0} >= {1'b0, rep});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
      ones    <= '0;
    end else if (clr || (en && last)) begin
      rep_cnt <= '0;
      ones    <= '0;
    end else if (en) begin
      rep_cnt <= rep_cnt + REP_W'(1);
      ones    <= ones_nxt;
    end
  end

endmodule

// File: rtl/adc_control_nonbinary.sv
// SAR controller for a redundant-weight differential CDAC: sample, MSB-first
// search with majority-voted low steps, then weighted binary result.
module adc_control_nonbinary
  import adc_control_nonbinary_pkg::*;
#(
  parameter int MATRIX_BITS = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   comparator_in,
  input  logic [2:0]             avg_control_in,
  output logic                   sample_out,
  output logic                   sample_out_n,
  output logic                   enable_loop_out,
  output logic                   conv_finished_strobe_out,
  output logic [MATRIX_BITS-1:0] pswitch_out,
  output logic [MATRIX_BITS-1:0] nswitch_out,
  output logic [MATRIX_BITS-1:0] result_out
);

  localparam int IW = $clog2(MATRIX_BITS);
  localparam int AW = MATRIX_BITS + 1;

  state_t                 state, state_nxt;
  logic [IW-1:0]          idx;
  logic [REP_W-1:0]       rep_q;
  logic [MATRIX_BITS-1:0] dec_q, dec_nxt;
  logic [MATRIX_BITS-1:0] onehot, above;
  logic [MATRIX_BITS-1:0] result_q;
  logic [AW-1:0]          acc;
  logic                   avg_step, step_last, vote, bit_dec, bit_done;

  assign avg_step = (idx < IW'(N_AVG_STEPS));
  assign onehot   = MATRIX_BITS'(1) << idx;
  // Bits strictly above the one under test are already decided.
  assign above    = ~((onehot << 1) - MATRIX_BITS'(1));
  assign bit_dec  = avg_step ? vote : comparator_in;
  assign bit_done = (state == ST_STEP) && (!avg_step || step_last);

  adc_avg_vote u_vote (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (state != ST_STEP),
    .en            ((state == ST_STEP) && avg_step),
    .comparator_in (comparator_in),
    .rep           (rep_q),
    .last          (step_last),
    .vote          (vote)
  );

  always_comb begin
    dec_nxt = dec_q;
    if (bit_done) dec_nxt[idx] = bit_dec;
  end

  // Weighted sum including the decision being made this cycle.
  always_comb begin
    acc = '0;
    for (int i = 0; i < MATRIX_BITS; i++) begin
      if (dec_nxt[i]) acc = acc + AW'(weight(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_SAMPLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_SAMPLE: state_nxt = ST_STEP;
      ST_STEP:   if (bit_done && idx == '0) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_SAMPLE;
      default:   state_nxt = ST_SAMPLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      rep_q    <= REP_W'(1);
      dec_q    <= '0;
      result_q <= '0;
    end else begin
      case (state)
        ST_SAMPLE: begin
          rep_q <= avg_to_rep(avg_control_in);
          dec_q <= '0;
          idx   <= IW'(MATRIX_BITS - 1);
        end
        ST_STEP: begin
          if (bit_done) begin
            dec_q <= dec_nxt;
            if (idx == '0) begin
              // Overflow is impossible with the shipped weights; clamp anyway.
              result_q <= acc[MATRIX_BITS] ? '1 : acc[MATRIX_BITS-1:0];
            end else begin
              idx <= idx - IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sample_out               = (state == ST_SAMPLE);
  assign sample_out_n             = ~sample_out;
  assign enable_loop_out          = (state == ST_STEP);
  assign conv_finished_strobe_out = (state == ST_DONE);
  assign pswitch_out              = (state == ST_STEP) ? (dec_q | onehot) : '0;
  assign nswitch_out              = (state == ST_STEP) ? (~dec_q & above) : '0;
  assign result_out               = result_q;

endmodule

// File: tb/tb_adc_control_nonbinary.sv
// Self-checking bench: table vectors, hand-written averaging/reset cases and
// randomized conversions checked against a weighted-vote reference model.
module tb_adc_control_nonbinary;

  localparam int MB = 10;
  localparam int WREF [10] = '{5, 6, 10, 18, 40, 64, 96, 144, 240, 400};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          comparator_in = 1'b0;
  logic [2:0]    avg_control_in = 3'd0;
  logic          sample_out, sample_out_n, enable_loop_out, conv_finished_strobe_out;
  logic [MB-1:0] pswitch_out, nswitch_out, result_out;

  adc_control_nonbinary #(.MATRIX_BITS(MB)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .comparator_in            (comparator_in),
    .avg_control_in           (avg_control_in),
    .sample_out               (sample_out),
    .sample_out_n             (sample_out_n),
    .enable_loop_out          (enable_loop_out),
    .conv_finished_strobe_out (conv_finished_strobe_out),
    .pswitch_out              (pswitch_out),
    .nswitch_out              (nswitch_out),
    .result_out               (result_out)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  int          n_inv_bad = 0;
  int          stim[$];
  logic [9:0]  p_log[$];
  logic [9:0]  n_log[$];
  int          prev_exp = 0;
  bit          have_prev = 0;

  typedef struct {
    logic [2:0] avg;
    logic [9:0] bits;
    int         exp;
    string      name;
  } vec_t;

  always @(negedge clk) if (sample_out_n !== ~sample_out) n_inv_bad++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  function automatic int rmap(input logic [2:0] a);
    case (a)
      3'd0:    return 1;
      3'd1:    return 4;
      3'd2:    return 8;
      3'd3:    return 16;
      default: return 32;
    endcase
  endfunction

  // Reference: walk the comparator stream, one sample per upper bit and
  // r samples per averaged bit, majority (ties up) then sum the weights.
  function automatic int model(input int r);
    int pos = 0;
    int sum = 0;
    for (int b = 9; b >= 0; b--) begin
      int reps = (b >= 4) ? 1 : r;
      int ones = 0;
      for (int k = 0; k < reps; k++) begin
        ones += stim[pos];
        pos++;
      end
      if (2 * ones >= reps) sum += WREF[b];
    end
    return sum;
  endfunction

  task automatic build_bits(input logic [9:0] bits, input int r);
    stim.delete();
    for (int b = 9; b >= 4; b--) stim.push_back(int'(bits[b]));
    for (int b = 3; b >= 0; b--) repeat (r) stim.push_back(int'(bits[b]));
  endtask

  task automatic build_rand(input int r);
    stim.delete();
    for (int b = 9; b >= 4; b--) stim.push_back(int'($urandom_range(0, 1)));
    for (int b = 3; b >= 0; b--) begin
      int p = int'($urandom_range(0, 100));
      repeat (r) stim.push_back(int'($urandom_range(0, 99)) < p ? 1 : 0);
    end
  endtask

  function automatic int cnt_step(input int b);
    int c = 0;
    logic [9:0] m, t;
    m = 10'((1 << (b + 1)) - 1);
    t = 10'(1 << b);
    foreach (p_log[k]) if ((p_log[k] & m) == t) c++;
    return c;
  endfunction

  task automatic wait_sample(input string name, output bit ok);
    int waited = 0;
    @(negedge clk);
    while (!sample_out && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    ok = sample_out;
    if (!ok) chk({name, " sync"}, 32'(sample_out), 32'd1);
  endtask

  task automatic convert(input string name, input logic [2:0] avg, input int exp);
    int r, n;
    bit bad, ok;
    wait_sample(name, ok);
    if (!ok) return;
    chk({name, " sample_idle"},
        {9'd0, enable_loop_out, conv_finished_strobe_out, pswitch_out, nswitch_out}, 32'd0);
    if (have_prev) chk({name, " hold"}, 32'(result_out), 32'(prev_exp));
    avg_control_in = avg;
    r = rmap(avg);
    n = 6 + 4 * r;
    p_log.delete();
    n_log.delete();
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1 comparator_in = (stim[k] != 0);
      avg_control_in = 3'($urandom);
      @(negedge clk);
      if (!enable_loop_out || sample_out || conv_finished_strobe_out) bad = 1;
      if (have_prev && result_out !== 10'(prev_exp)) bad = 1;
      p_log.push_back(pswitch_out);
      n_log.push_back(nswitch_out);
    end
    @(posedge clk);
    #1 comparator_in = 1'($urandom);
    @(negedge clk);
    chk({name, " step_timing"}, 32'(bad), 32'd0);
    chk({name, " done_outputs"},
        {9'd0, conv_finished_strobe_out, enable_loop_out, sample_out, pswitch_out, nswitch_out},
        {9'd0, 1'b1, 1'b0, 1'b0, 20'd0});
    chk({name, " result"}, 32'(result_out), 32'(exp));
    prev_exp  = exp;
    have_prev = 1;
  endtask

  initial begin
    vec_t tbl [7];
    bit   ok;
    tbl[0] = '{3'd0, 10'h000, 0,    "all0"};
    tbl[1] = '{3'd0, 10'h100, 240,  "d8"};
    tbl[2] = '{3'd0, 10'h00F, 39,   "low4"};
    tbl[3] = '{3'd0, 10'h2AA, 632,  "alt10"};
    tbl[4] = '{3'd0, 10'h155, 391,  "alt01"};
    tbl[5] = '{3'd0, 10'h3FF, 1023, "all1"};
    tbl[6] = '{3'd1, 10'h20F, 439,  "r4"};

    repeat (3) @(negedge clk);
    chk("reset_state",
        {9'd0, sample_out, sample_out_n, enable_loop_out, conv_finished_strobe_out,
         pswitch_out, nswitch_out, result_out},
        {9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 30'd0});
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      build_bits(tbl[i].bits, rmap(tbl[i].avg));
      convert(tbl[i].name, tbl[i].avg, tbl[i].exp);
      if (i == 1) begin
        chk("step7_pswitch", 32'(p_log[2]), 32'h180);
        chk("step7_nswitch", 32'(n_log[2]), 32'h200);
      end
    end

    // R=8: bit3 two ones -> 0, bit2 four ones (tie) -> 1, bit1 all ones, bit0 none.
    stim.delete();
    repeat (6) stim.push_back(0);
    stim.push_back(0); stim.push_back(1); stim.push_back(0); stim.push_back(1);
    repeat (4) stim.push_back(0);
    stim.push_back(1); stim.push_back(1); stim.push_back(0); stim.push_back(0);
    stim.push_back(1); stim.push_back(1); stim.push_back(0); stim.push_back(0);
    repeat (8) stim.push_back(1);
    repeat (8) stim.push_back(0);
    convert("avg8", 3'd2, 16);
    chk("avg8_bit3_len", 32'(cnt_step(3)), 32'd8);
    chk("avg8_bit2_len", 32'(cnt_step(2)), 32'd8);

    build_bits(10'h3FF, 32);
    convert("avg7_r32", 3'd7, 1023);

    // Reset asserted while step 5 is under test.
    wait_sample("midreset", ok);
    if (ok) begin
      avg_control_in = 3'd0;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk);
        #1 comparator_in = 1'b1;
        @(negedge clk);
      end
      chk("step5_pswitch", 32'(pswitch_out), 32'h3E0);
      #2 rst_n = 1'b0;
      #1 chk("midreset_outputs",
             {9'd0, sample_out, sample_out_n, enable_loop_out, conv_finished_strobe_out,
              pswitch_out, nswitch_out, result_out},
             {9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 30'd0});
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      prev_exp  = 0;
      have_prev = 1;
      build_rand(1);
      convert("post_reset", 3'd0, model(1));
    end

    for (int i = 0; i < 10; i++) begin
      logic [2:0] a;
      a = 3'($urandom_range(0, 7));
      build_rand(rmap(a));
      convert("rand", a, model(rmap(a)));
    end

    chk("sample_n_inverse", 32'(n_inv_bad), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/adc_control_nonbinary.md
# adc_control_nonbinary

Digital successive-approximation controller for a differential SAR ADC whose capacitor DAC has non-binary (redundant) weights. It drives the sample switches and the per-capacitor P/N switch matrix, clocks the comparator loop, and converts the comparator decisions into a weighted binary result. Optional oversampling of the lowest steps uses majority voting. The block sits between the analog SAR core (comparator, capacitor matrix) and the digital readout.

## Interface
- `MATRIX_BITS`, default 10: number of DAC capacitors, which is also the number of conversion steps and the result width.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `comparator_in` in 1: comparator decision. 1 means the input is above the DAC level, so the tested bit is kept.
- `avg_control_in` in 3: averaging select, latched at the end of the SAMPLE cycle.
- `sample_out` out 1: sample switches closed.
- `sample_out_n` out 1: always the inverse of `sample_out`.
- `enable_loop_out` out 1: comparator loop enable; high during conversion steps.
- `conv_finished_strobe_out` out 1: one-cycle pulse when `result_out` updates.
- `pswitch_out` out MATRIX_BITS: capacitors switched to the P reference.
- `nswitch_out` out MATRIX_BITS: capacitors switched to the N reference.
- `result_out` out MATRIX_BITS: last completed conversion code.

## Operation
- FSM states: SAMPLE → STEP (MATRIX_BITS steps, MSB index first) → DONE → SAMPLE, free-running.
- SAMPLE (1 cycle):
  - `sample_out`=1, `enable_loop_out`=0, both switch buses 0.
  - Latches averaging repeat count R: avg 0→1, 1→4, 2→8, 3→16, 4–7→32.
- STEP i (i = MATRIX_BITS-1 down to 0):
  - `enable_loop_out`=1.
  - `pswitch_out` = decided-one bits OR bit i.
  - `nswitch_out` = decided-zero bits.
  - Upper steps (i ≥ 4) take one cycle; `comparator_in` is sampled at the cycle's final rising edge and becomes d_i.
  - Averaged steps (i = 3..0) hold bit i for R cycles and count ones; d_i = 1 iff 2·ones ≥ R (a tie resolves to 1).
  - With R=1, the averaged steps behave like the upper steps.
- DONE (1 cycle):
  - `result_out` = Σ d_i·W[i], registered on entry to DONE.
  - `conv_finished_strobe_out`=1, `enable_loop_out`=0, switches 0.
- Weight table W (index 9..0): 400, 240, 144, 96, 64, 40, 18, 10, 6, 5.
  - Sum is exactly 1023.
  - Each weight satisfies W[i] ≤ 1 + Σ W[j<i].
  - The result sum uses an accumulator of MATRIX_BITS+1 bits internally; the sum cannot exceed 1023, so no saturation is needed.
- `avg_control_in` changes outside SAMPLE have no effect on the current conversion.

## Timing
- Reset values (async, while `rst_n`=0):
  - State SAMPLE; `sample_out`=1, `sample_out_n`=0.
  - `enable_loop_out`=0, `conv_finished_strobe_out`=0.
  - `pswitch_out`=0, `nswitch_out`=0, `result_out`=0.
  - Ones counter and decision register cleared.
- Reset release: the first SAMPLE cycle is the first full clock after `rst_n` rises.
- Conversion length is 1 + 6 + 4·R + 1 cycles: 12 cycles for R=1, 136 cycles for R=32.
- Latency from the end of SAMPLE to the strobe is 6 + 4·R cycles.
- Reset mid-conversion: abort immediately; partial decisions are discarded and `result_out` is cleared.
- `result_out` is stable between strobes.
- The strobe never coincides with `sample_out`=1.

## Structure
- Package `adc_control_nonbinary_pkg` holds:
  - the weight array W;
  - `N_AVG_STEPS`=4;
  - the avg→R mapping function;
  - the FSM state enum.
- One natural sub-module, `adc_avg_vote`: the repeat counter plus ones counter with majority output, reset by the FSM at each averaged step.

## Test plan
- avg=0, all decisions 0 → `result_out`=0. Strobe occurs 11 cycles after the SAMPLE cycle; the conversion takes 12 cycles total.
- avg=0, decisions d9..d0 = 0,1,0,0,0,0,0,0,0,0 → 240. Mid-conversion check: during step 7, `pswitch_out`=0x180 and `nswitch_out`=0x200.
- avg=0, only d3..d0 = 1 → 39. Then decisions 1,0,1,0… for the upper bits → `result_out` = 400+144 plus the lower contributions, checked against Σ W.
- avg=2 (R=8), bit-3 votes 0,1,0,1,0,0,0,0 → d3=0; bit-2 votes with four ones → d2=1 (tie resolves to 1). Each averaged step lasts 8 cycles.
- avg=7 (treated as avg=4, R=32), comparator held at 1 → 1023 after 136 cycles.
- Assert `rst_n` during step 5 → all outputs return to reset values asynchronously. After release, a clean conversion gives the expected code, with `sample_out_n` = ~`sample_out` throughout.
